// File: rtl/fact_pkg.sv
// ============================================================================
// Module   : fact_pkg
// Brief    : Shared types and constants for the factorial compute engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fact_pkg;

    localparam int RES_W       = 128;
    localparam int OPND_W      = 64;
    localparam int MUL_CYCLES  = 64;
    localparam int OD_DONE_BIT = 1;
    localparam int OD_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } fact_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_mult_128x64.sv
// ============================================================================
// Module   : seq_mult_128x64
// Brief    : Shift-add multiplier, 128-bit x 64-bit, truncated 128-bit product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult_128x64
    import fact_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start,
    input  logic [RES_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0] p,
    output logic             valid
);

    logic [RES_W-1:0]  a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;
    logic [RES_W-1:0]  p_q, p_d;
    logic [6:0]        step_q, step_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        step_d  = step_q;
        busy_d  = busy_q;
        valid_d = 1'b0;

        if (clear) begin
            a_d    = '0;
            b_d    = '0;
            p_d    = '0;
            step_d = '0;
            busy_d = 1'b0;
        end else if (start) begin
            // The loading edge already performs the first of the 64 steps.
            p_d    = b[0] ? a : '0;
            a_d    = a << 1;
            b_d    = b >> 1;
            step_d = 7'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            p_d = p_q + (b_q[0] ? a_q : '0);
            a_d = a_q << 1;
            b_d = b_q >> 1;
            if (step_q == 7'(MUL_CYCLES - 1)) begin
                step_d  = '0;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else begin
                step_d = step_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign p     = p_q;
    assign valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/factorial_core.sv
// ============================================================================
// Module   : factorial_core
// Brief    : Iterative N! engine built on a sequential shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module factorial_core
    import fact_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic              intr_en,
    input  logic [OPND_W-1:0] operand,
    output logic [1:0]        op_done,
    output logic [OPND_W-1:0] result_h,
    output logic [OPND_W-1:0] result_l,
    output logic              interrupt
);

    fact_state_e       state_q, state_d;
    logic              start_q, start_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic [OPND_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [1:0]        op_done_q, op_done_d;
    logic              interrupt_q, interrupt_d;

    logic              start_rise;
    logic [OPND_W-1:0] cnt_dec;
    logic              m_start;
    logic [RES_W-1:0]  m_a;
    logic [OPND_W-1:0] m_b;
    logic [RES_W-1:0]  m_p;
    logic              m_valid;

    assign start_rise = op_start & ~start_q;
    assign cnt_dec    = cnt_q - 64'd1;

    always_comb begin
        state_d  = state_q;
        start_d  = op_start;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        m_start  = 1'b0;
        m_a      = acc_q;
        m_b      = cnt_q;

        if (op_clear) begin
            state_d  = ST_IDLE;
            start_d  = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_rise) state_d = ST_INIT;
                end
                ST_INIT: begin
                    acc_d = RES_W'(1);
                    cnt_d = operand;
                    if (operand <= 64'd1) begin
                        state_d  = ST_DONE;
                        result_d = RES_W'(1);
                    end else begin
                        m_start = 1'b1;
                        m_a     = RES_W'(1);
                        m_b     = operand;
                        state_d = ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Next factor is launched on the capture edge: no bubbles.
                    if (m_valid) begin
                        acc_d = m_p;
                        cnt_d = cnt_dec;
                        if (cnt_dec == 64'd1) begin
                            state_d  = ST_DONE;
                            result_d = m_p;
                        end else begin
                            m_start = 1'b1;
                            m_a     = m_p;
                            m_b     = cnt_dec;
                        end
                    end
                end
                ST_DONE: begin
                    if (start_rise) state_d = ST_INIT;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        op_done_d               = 2'b00;
        op_done_d[OD_DONE_BIT]  = (state_d == ST_DONE);
        op_done_d[OD_BUSY_BIT]  = (state_d == ST_INIT) || (state_d == ST_MUL);
        interrupt_d             = intr_en & op_done_d[OD_DONE_BIT];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            op_done_q   <= 2'b00;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            op_done_q   <= op_done_d;
            interrupt_q <= interrupt_d;
        end
    end

    seq_mult_128x64 u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (op_clear),
        .start   (m_start),
        .a       (m_a),
        .b       (m_b),
        .p       (m_p),
        .valid   (m_valid)
    );

    assign op_done   = op_done_q;
    assign result_h  = result_q[RES_W-1:OPND_W];
    assign result_l  = result_q[OPND_W-1:0];
    assign interrupt = interrupt_q;

endmodule

`default_nettype wire

// File: tb/tb_factorial_core.sv
// ============================================================================
// Module   : tb_factorial_core
// Brief    : Self-checking bench for factorial_core against a plain N! model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_factorial_core;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         op_start;
    logic         op_clear;
    logic         intr_en;
    logic [63:0]  operand;
    logic [1:0]   op_done;
    logic [63:0]  result_h;
    logic [63:0]  result_l;
    logic         interrupt;

    int           total = 0;
    int           bad   = 0;
    logic [127:0] last_res;

    always #5 clk = ~clk;

    factorial_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_clear  (op_clear),
        .intr_en   (intr_en),
        .operand   (operand),
        .op_done   (op_done),
        .result_h  (result_h),
        .result_l  (result_l),
        .interrupt (interrupt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_fact(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int k = 2; k <= n; k++) r = r * 128'(k);
        return r;
    endfunction

    function automatic int ref_lat(input int n);
        return 2 + 64 * ((n > 1) ? n - 1 : 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run from a start rise to op_done[1]; optionally fires a second rise mid-run.
    task automatic run(input int n, input logic ie, input bit extra_rise);
        int edges;
        bit seen;
        operand  = 64'(n);
        intr_en  = ie;
        op_start = 1'b1;
        edges    = 0;
        seen     = 0;
        while (!seen && edges < ref_lat(n) + 50) begin
            tick();
            edges++;
            if (edges == 1) begin
                chk("busy_after_start", 128'(op_done), 128'(2'b01));
                chk("hold_prev_result", {result_h, result_l}, last_res);
            end
            if (edges == 2) operand = {$urandom, $urandom};
            if (extra_rise && edges == 5) op_start = 1'b0;
            if (extra_rise && edges == 6) op_start = 1'b1;
            if (op_done[1]) seen = 1;
        end
        chk("latency", 128'(edges), 128'(ref_lat(n)));
        chk("done_status", 128'(op_done), 128'(2'b10));
        chk("result", {result_h, result_l}, ref_fact(n));
        chk("irq_at_done", 128'(interrupt), 128'(ie));
        last_res = ref_fact(n);
        op_start = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        intr_en  = 1'b0;
        operand  = '0;
        last_res = '0;
        repeat (3) tick();
        chk("reset_op_done", 128'(op_done), 128'd0);
        chk("reset_result", {result_h, result_l}, 128'd0);
        chk("reset_irq", 128'(interrupt), 128'd0);
        reset_n = 1'b1;
        tick();

        run(5, 1'b0, 1'b0);
        chk("n5_const", {result_h, result_l}, {64'h0, 64'h78});
        run(0, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(21, 1'b0, 1'b0);
        chk("n21_const", {result_h, result_l}, {64'h2, 64'hC5077D36B8C40000});
        run(20, 1'b0, 1'b0);
        chk("n20_const", {result_h, result_l}, {64'h0, 64'h21C3677C82B40000});

        run(3, 1'b1, 1'b0);
        intr_en = 1'b0;
        tick();
        chk("irq_drop", 128'(interrupt), 128'd0);
        chk("done_holds", 128'(op_done), 128'(2'b10));

        // Clear in the middle of a multiply step.
        operand  = 64'd5;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (71) tick();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        chk("clear_op_done", 128'(op_done), 128'd0);
        chk("clear_result", {result_h, result_l}, 128'd0);
        chk("clear_irq", 128'(interrupt), 128'd0);
        last_res = '0;
        repeat (3) tick();
        chk("clear_stays_idle", 128'(op_done), 128'd0);
        run(5, 1'b0, 1'b1);

        // Asynchronous reset mid-multiply, checked before any further edge.
        operand  = 64'd4;
        intr_en  = 1'b1;
        op_start = 1'b1;
        repeat (100) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_op_done", 128'(op_done), 128'd0);
        chk("async_rst_result", {result_h, result_l}, 128'd0);
        chk("async_rst_irq", 128'(interrupt), 128'd0);
        op_start = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        last_res = '0;
        repeat (3) tick();
        chk("post_rst_idle", 128'(op_done), 128'd0);

        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(0, 36)), 1'($urandom_range(0, 1)), 1'b0);
        end
        run(int'($urandom_range(3, 12)), 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/factorial_core.md
Name: factorial_core

Overview:
- Compute engine downstream of the factorial bus-register controller.
- Consumes the controller's start, clear, interrupt-enable and 64-bit operand outputs, and computes N! iteratively with a sequential shift-add multiplier.
- Returns a 2-bit status and a 128-bit result, split high/low, which the controller reads back over the bus.
- Drives the interrupt line to the host.

Parameters:
- MUL_CYCLES, 64, cycles per multiply step; equals operand width; fixed, not for override.
- RES_W, 128, result width; result_h is bits [127:64], result_l is bits [63:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_start  in  1  start level from controller; only a 0->1 transition starts a run.
- op_clear  in  1  synchronous clear from controller.
- intr_en  in  1  interrupt enable.
- operand  in  64  N; sampled only in INIT.
- op_done  out  2  status; [1]=done, [0]=busy.
- result_h  out  64  upper half of N!.
- result_l  out  64  lower half of N!.
- interrupt  out  1  equals intr_en & op_done[1], registered.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset: state=IDLE; op_done=2'b00; result_h=0; result_l=0; interrupt=0; start-edge register=0; counter=0; multiplier cleared.
- op_clear=1 at an edge is the highest-priority synchronous event. It forces the same values as reset, and a start edge in the same cycle is discarded.
- Start detect: start_q <= op_start. Rise = op_start & ~start_q. A rise is accepted only in IDLE or DONE. A rise during INIT or MUL is ignored and never queued.
- FSM states: IDLE, INIT, MUL, DONE.
- IDLE: op_done=00. On rise -> INIT.
- INIT (1 cycle): acc=1, cnt=operand, op_done=01.
  - If operand<=1 -> DONE with acc=1, so 0!=1 and 1!=1.
  - Else start multiplier with (acc, cnt) -> MUL.
- MUL: multiplier runs exactly 64 cycles, then acc <= product[127:0] (truncated modulo 2^128) and cnt <= cnt-1.
  - If the new cnt==1 -> DONE.
  - Else restart the multiplier with (acc, cnt) in the same cycle; there are no bubble cycles between factors.
- DONE: op_done=10; result_h/result_l hold acc. A rise -> INIT, which restarts the run.
- Latency: op_done[1] is first visible after 2 + 64*max(N-1,0) rising edges, counted from and including the edge that samples the op_start rise.
- Results update only on entry to DONE. They hold the previous result in IDLE, INIT and MUL after a re-start; they are not zeroed.
- Overflow: N>=35 wraps modulo 2^128 silently; there is no error flag.
- Operand changes after INIT have no effect on the run in progress.
- Interrupt stays high while DONE and intr_en=1. It drops one cycle after intr_en falls or after op_clear.
- Reset mid-run: immediate return to the reset values; no partial result is visible.

Decomposition:
- Shared package fact_pkg holds:
  - the state enum (IDLE/INIT/MUL/DONE);
  - OD_DONE_BIT=1 and OD_BUSY_BIT=0;
  - RES_W=128 and OPND_W=64.
- Sub-module seq_mult_128x64:
  - Inputs: start, a[127:0], b[63:0].
  - Each cycle: if b[0], p+=a; then a<<=1, b>>=1.
  - Outputs: p[127:0] and a one-cycle valid after 64 cycles.
  - It has the same clk/reset_n and its own synchronous clear input driven by op_clear.

Test Plan:
- Reset then N=5, op_start 0->1 -> op_done=01 next cycle; op_done=10 after 258 edges; result_h=0, result_l=0x78.
- N=0 and N=1 -> op_done=10 after 2 edges; result={0,1}.
- N=21 -> result_h=0x2, result_l=0xC5077D36B8C40000, after 1282 edges; N=20 -> result_h=0, result_l=0x21C3677C82B40000.
- op_clear at MUL cycle 70 of N=5 -> next edge op_done=00, results=0; later op_start toggle 0->1 restarts from INIT; a second rise during busy is ignored and the latency is unchanged.
- intr_en=1 with N=3 -> interrupt rises together with op_done[1] (130 edges); dropping intr_en clears it next cycle; intr_en=0 keeps it low.
- Assert reset_n low mid-MUL asynchronously -> outputs zero immediately with no clock; after release, the FSM is in IDLE and the held-high op_start does not start a run until it toggles.
